// File: rtl/parser_ingress_arbiter.sv
// parser_ingress_arbiter: packet-atomic round-robin sharing of one parser between N_SRC sources, with source-tagged results
module parser_ingress_arbiter #(
    parameter int N_SRC     = 4,
    parameter int BUS_W_B   = 8,
    parameter int MIN_GAP   = 1,
    parameter int MAX_WORDS = 256,
    parameter int PHS_LAT   = 4,
    parameter int PHS_W     = 120
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic [N_SRC*BUS_W_B*8-1:0]   src_data_i,
    input  logic [N_SRC-1:0]             src_valid_i,
    input  logic [N_SRC-1:0]             src_sop_i,
    input  logic [N_SRC-1:0]             src_eop_i,
    output logic [N_SRC-1:0]             src_ready_o,
    output logic [BUS_W_B*8-1:0]         bus_o,
    output logic                         start_of_packet_o,
    input  logic [PHS_W-1:0]             phs_i,
    output logic [PHS_W-1:0]             phs_o,
    output logic                         phs_valid_o,
    output logic [$clog2(N_SRC)-1:0]     phs_src_o,
    output logic [N_SRC-1:0]             grant_o,
    output logic                         busy_o,
    output logic                         err_underrun_o,
    output logic                         err_oversize_o
);
    localparam int W  = BUS_W_B * 8;
    localparam int IW = $clog2(N_SRC);
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

    state_t            state, state_nx, post_st;
    logic [IW-1:0]     rr_ptr, gid, win, idx;
    logic              found, acc, eop, last;
    logic [N_SRC-1:0]  elig;
    logic [CW-1:0]     cnt;
    logic [3:0]        gap_cnt;
    logic [PHS_LAT-1:0] tag_v;
    logic [IW-1:0]     tag_id [PHS_LAT];

    assign elig        = src_valid_i & src_sop_i;
    assign src_ready_o = (state == XFER || state == DROP) ? grant_o : '0;
    assign acc         = |(src_valid_i & src_ready_o);
    assign eop         = src_eop_i[gid];
    assign last        = cnt == CW'(MAX_WORDS - 1);
    assign busy_o      = state != IDLE;
    assign post_st     = (MIN_GAP == 0) ? IDLE : GAP;

    // first eligible source strictly after rr_ptr, wrapping
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = IW'((int'(rr_ptr) + k) % N_SRC);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = found ? XFER : IDLE;
            XFER:    state_nx = !acc ? XFER : eop ? post_st : last ? DROP : XFER;
            DROP:    state_nx = (acc && eop) ? post_st : DROP;
            GAP:     state_nx = (gap_cnt == 4'(MIN_GAP - 1)) ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state             <= IDLE;
            rr_ptr            <= IW'(N_SRC - 1);
            gid               <= '0;
            grant_o           <= '0;
            cnt               <= '0;
            gap_cnt           <= '0;
            bus_o             <= '0;
            start_of_packet_o <= 1'b0;
            err_underrun_o    <= 1'b0;
            err_oversize_o    <= 1'b0;
            tag_v             <= '0;
            phs_valid_o       <= 1'b0;
            phs_o             <= '0;
            phs_src_o         <= '0;
            for (int i = 0; i < PHS_LAT; i++) tag_id[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                rr_ptr  <= win;
                gid     <= win;
                grant_o <= N_SRC'(1) << win;
                cnt     <= '0;
            end else if (state_nx == IDLE) begin
                grant_o <= '0;
            end
            if (state == XFER && acc) cnt <= cnt + 1'b1;
            gap_cnt           <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
            bus_o             <= (state == XFER && acc) ? src_data_i[int'(gid)*W +: W] : '0;
            start_of_packet_o <= state == XFER && acc && cnt == '0;
            err_underrun_o    <= state == XFER && !src_valid_i[gid];
            err_oversize_o    <= state == XFER && acc && last && !eop;
            // tag rides alongside the parser pipeline so its exit lines up with the matching phs
            tag_v[0]  <= start_of_packet_o;
            tag_id[0] <= gid;
            for (int i = 1; i < PHS_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            phs_valid_o <= tag_v[PHS_LAT-1];
            if (tag_v[PHS_LAT-1]) begin
                phs_o     <= phs_i;
                phs_src_o <= tag_id[PHS_LAT-1];
            end
        end
    end
endmodule

// File: tb/tb_parser_ingress_arbiter.sv
// tb_parser_ingress_arbiter: arbitration table, directed corner cases and randomized packets against a packet-level model
module tb_parser_ingress_arbiter;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int MG = 1;
    localparam int MW = 4;
    localparam int PL = 4;
    localparam int PW = 120;

    typedef struct {logic [63:0] d; bit sop; bit eop; bit bub;} drv_t;
    typedef struct {logic [63:0] d; bit sop; int src; int gap;} exp_t;
    typedef struct {int len; int bub_at; int bub_n; logic [31:0] base;} pkt_t;
    typedef struct {int due; int src; logic [PW-1:0] v;} tag_t;
    typedef struct {logic [3:0] req; logic [3:0] g;} arb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N*W-1:0] src_data = '0;
    logic [N-1:0] src_valid = '0, src_sop = '0, src_eop = '0;
    logic [N-1:0] src_ready, grant;
    logic [W-1:0] bus;
    logic sop_o, phs_valid, busy, err_u, err_o;
    logic [PW-1:0] phs_in = '0, phs_out;
    logic [1:0] phs_src;

    parser_ingress_arbiter #(.N_SRC(N), .BUS_W_B(8), .MIN_GAP(MG), .MAX_WORDS(MW), .PHS_LAT(PL), .PHS_W(PW)) dut (
        .CLK(clk), .reset(reset), .src_data_i(src_data), .src_valid_i(src_valid), .src_sop_i(src_sop),
        .src_eop_i(src_eop), .src_ready_o(src_ready), .bus_o(bus), .start_of_packet_o(sop_o),
        .phs_i(phs_in), .phs_o(phs_out), .phs_valid_o(phs_valid), .phs_src_o(phs_src), .grant_o(grant),
        .busy_o(busy), .err_underrun_o(err_u), .err_oversize_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0, last_c = 0, m_ptr = 3;
    int exp_over = 0, exp_under = 0, obs_over = 0, obs_under = 0;
    drv_t q[N][$];
    pkt_t pend[N][$];
    exp_t xq[$];
    tag_t tq[$];
    arb_t tbl[12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] f(int c);
        logic [127:0] t;
        t = {4{32'(c) * 32'h9E3779B1}};
        return t[PW-1:0];
    endfunction

    function automatic logic [63:0] wd(pkt_t p, int k);
        return {p.base | 32'h1, 32'(k)};
    endfunction

    function automatic bit done();
        bit e = xq.size() == 0 && tq.size() == 0 && !busy;
        for (int i = 0; i < N; i++) e = e && q[i].size() == 0;
        return e;
    endfunction

    task automatic add_pkt(input int s, input int len, input int bat, input int bn);
        pend[s].push_back('{len: len, bub_at: bat, bub_n: bn, base: $urandom});
    endtask

    // expand pending packets into per-source word streams and predict the bus in round-robin order
    task automatic launch();
        pkt_t p;
        int s, nw, pg;
        bit first = 1'b1;
        pg = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < pend[i].size(); j++) begin
                p = pend[i][j];
                for (int k = 0; k < p.len; k++) begin
                    if (k == p.bub_at && k > 0)
                        repeat (p.bub_n) q[i].push_back('{d: '0, sop: 1'b0, eop: 1'b0, bub: 1'b1});
                    q[i].push_back('{d: wd(p, k), sop: k == 0, eop: k == p.len - 1, bub: 1'b0});
                end
            end
        while (pend[0].size() + pend[1].size() + pend[2].size() + pend[3].size() > 0) begin
            s = -1;
            for (int k = 1; k <= N; k++)
                if (s < 0 && pend[(m_ptr + k) % N].size() > 0) s = (m_ptr + k) % N;
            m_ptr = s;
            p = pend[s].pop_front();
            nw = p.len > MW ? MW : p.len;
            for (int k = 0; k < nw; k++)
                xq.push_back('{d: wd(p, k), sop: k == 0, src: s,
                               gap: k == 0 ? (first ? -1 : pg) : (k == p.bub_at ? p.bub_n : 0)});
            pg = MG + 1 + (p.len > MW ? p.len - MW : 0);
            first = 1'b0;
            if (p.len > MW) exp_over++;
            exp_under += p.bub_n;
        end
    endtask

    task automatic monitor();
        exp_t e;
        tag_t t;
        chk("grant_onehot", 128'($onehot0(grant)), 1);
        chk("ready_in_grant", 128'((src_ready & ~grant) == 0), 1);
        chk("busy_vs_grant", busy, |grant);
        if (bus != 0 || sop_o) begin
            if (xq.size() == 0) chk("bus_extra", bus, 0);
            else begin
                e = xq.pop_front();
                chk("bus_word", bus, e.d);
                chk("bus_sop", sop_o, e.sop);
                if (e.gap >= 0) chk("bus_gap", cyc - last_c - 1, e.gap);
                if (e.sop) tq.push_back('{due: cyc + PL + 1, src: e.src, v: f(cyc + PL)});
            end
            last_c = cyc;
        end
        if (tq.size() > 0 && tq[0].due == cyc) begin
            t = tq.pop_front();
            chk("phs_valid", phs_valid, 1);
            chk("phs_src", phs_src, t.src);
            chk("phs_data", phs_out, t.v);
        end else chk("phs_idle", phs_valid, 0);
        obs_over += int'(err_o);
        obs_under += int'(err_u);
    endtask

    task automatic step();
        logic [N-1:0] rdy;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && !q[i][0].bub) begin
                src_valid[i] = 1'b1;
                src_sop[i] = q[i][0].sop;
                src_eop[i] = q[i][0].eop;
                src_data[i*W +: W] = q[i][0].d;
            end else begin
                src_valid[i] = 1'b0;
                src_sop[i] = 1'b0;
                src_eop[i] = 1'b0;
            end
        end
        phs_in = f(cyc);
        rdy = src_ready;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++)
            if (rdy[i] && q[i].size() > 0) void'(q[i].pop_front());
        monitor();
    endtask

    task automatic drain();
        for (int n = 0; n < 2000 && !done(); n++) step();
        chk("drain_done", 128'(done()), 1);
        chk("underrun_total", obs_under, exp_under);
        chk("oversize_total", obs_over, exp_over);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src_valid = '0;
        src_sop = '0;
        src_eop = '0;
        src_data = '0;
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_bus", bus, 0);
        chk("rst_sop", sop_o, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", src_ready, 0);
        chk("rst_phs_valid", phs_valid, 0);
        chk("rst_phs", phs_out, 0);
        chk("rst_phs_src", phs_src, 0);
        chk("rst_err_u", err_u, 0);
        chk("rst_err_o", err_o, 0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            pend[i].delete();
        end
        xq.delete();
        tq.delete();
        m_ptr = 3;
    endtask

    initial begin
        int u0, o0, len, bat, bn;
        tbl = '{'{4'b0001, 4'b0001}, '{4'b0011, 4'b0010}, '{4'b1100, 4'b0100}, '{4'b1111, 4'b0001},
                '{4'b1010, 4'b0010}, '{4'b1000, 4'b1000}, '{4'b0101, 4'b0001}, '{4'b1011, 4'b1000},
                '{4'b0110, 4'b0100}, '{4'b0001, 4'b0001}, '{4'b1110, 4'b0010}, '{4'b0100, 4'b0100}};
        do_reset();
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) if (tbl[r].req[i]) add_pkt(i, 1, 0, 0);
            launch();
            step();
            chk("arb_grant", grant, tbl[r].g);
            drain();
        end
        // single 3-word packet: grant one cycle after the request
        do_reset();
        add_pkt(0, 3, 0, 0);
        launch();
        step();
        chk("t1_grant", grant, 4'b0001);
        drain();
        // three sources contending, source 0 has a second packet
        do_reset();
        add_pkt(0, 2, 0, 0); add_pkt(1, 2, 0, 0); add_pkt(2, 2, 0, 0); add_pkt(0, 2, 0, 0);
        launch();
        drain();
        // two-cycle bubble after word 1 of a 4-word packet
        u0 = obs_under;
        add_pkt(1, 4, 1, 2);
        launch();
        drain();
        chk("t3_underrun", obs_under - u0, 2);
        // oversize packet is truncated, following packet is normal
        o0 = obs_over;
        add_pkt(2, 6, 0, 0); add_pkt(0, 2, 0, 0);
        launch();
        drain();
        chk("t4_oversize", obs_over - o0, 1);
        // reset mid-packet: leftover continuation words must never be granted
        add_pkt(0, 4, 0, 0);
        launch();
        for (int n = 0; n < 10 && !sop_o; n++) step();
        chk("t5_sop_seen", sop_o, 1);
        do_reset();
        q[0].push_back('{d: 64'h5555, sop: 1'b0, eop: 1'b0, bub: 1'b0});
        add_pkt(3, 2, 0, 0);
        launch();
        step();
        chk("t5_grant_src3", grant, 4'b1000);
        q[0].delete();
        drain();
        // back-to-back single-word packets with a competing source
        do_reset();
        add_pkt(1, 1, 0, 0); add_pkt(1, 1, 0, 0); add_pkt(2, 1, 0, 0);
        launch();
        drain();
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++)
                repeat ($urandom_range(0, 2)) begin
                    len = $urandom_range(1, 6);
                    bat = 0;
                    bn = 0;
                    if (len > 1 && len <= MW && $urandom_range(0, 1) == 1) begin
                        bat = $urandom_range(1, len - 1);
                        bn = $urandom_range(1, 3);
                    end
                    add_pkt(i, len, bat, bn);
                end
            launch();
            drain();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
